// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
// Instruction queue sitting between fetch and the dual-issue decode stage.
// Fetch pushes at most one {pc, inst} pair per cycle. Decode sees the two
// oldest entries through a show-ahead head and pops zero, one or two of them
// per cycle, in program order. A flush empties the queue in one cycle.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst                 synchronous reset, active-low
//   flush               pipeline flush / exception, empties the queue
//   w_ena/w_pc/w_inst   fetch write strobe and payload
//   full                occupancy == DEPTH, fetch stalls while high
//   r_ena1/r_ena2       decode consumes head / second entry
//   r_valid1/r_pc1/r_inst1   head entry (show-ahead)
//   r_valid2/r_pc2/r_inst2   second entry (show-ahead)
//   empty               occupancy == 0
//   count               occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module inst_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          w_ena,
    input  logic [31:0]   w_pc,
    input  logic [31:0]   w_inst,
    output logic          full,
    input  logic          r_ena1,
    input  logic          r_ena2,
    output logic          r_valid1,
    output logic [31:0]   r_pc1,
    output logic [31:0]   r_inst1,
    output logic          r_valid2,
    output logic [31:0]   r_pc2,
    output logic [31:0]   r_inst2,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW:0]   w_count_nxt;
    logic [AW-1:0] w_rd_ptr2;
    logic          w_push;
    logic          w_pop1;
    logic          w_pop2;
    logic [1:0]    w_pop_cnt;
    logic [63:0]   w_head1;
    logic [63:0]   w_head2;

    // Status flags come from the registered count only, so a pop in the same
    // cycle never frees room for a write that arrives while full.
    assign full     = (r_count == FullCount);
    assign empty    = (r_count == '0);
    assign r_valid1 = !empty;
    assign r_valid2 = (r_count >= (AW+1)'(2));
    assign count    = r_count;

    // Slot 2 wraps on its own when the head sits at the last index.
    assign w_rd_ptr2 = r_rd_ptr + AW'(1);
    assign w_head1   = r_mem[r_rd_ptr];
    assign w_head2   = r_mem[w_rd_ptr2];

    assign r_pc1   = r_valid1 ? w_head1[63:32] : 32'h0;
    assign r_inst1 = r_valid1 ? w_head1[31:0]  : 32'h0;
    assign r_pc2   = r_valid2 ? w_head2[63:32] : 32'h0;
    assign r_inst2 = r_valid2 ? w_head2[31:0]  : 32'h0;

    // Pops only count against entries already present; r_ena2 alone is inert.
    assign w_push    = w_ena & !full;
    assign w_pop1    = r_ena1 & r_valid1;
    assign w_pop2    = r_ena1 & r_ena2 & r_valid2;
    assign w_pop_cnt = {1'b0, w_pop1} + {1'b0, w_pop2};

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(w_push);
            w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop_cnt);
            w_count_nxt  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Storage is deliberately left uninitialised; valid gating hides stale data.
    always_ff @(posedge clk) begin
        if (rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= {w_pc, w_inst};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          w_ena;
    logic [31:0]   w_pc;
    logic [31:0]   w_inst;
    logic          full;
    logic          r_ena1;
    logic          r_ena2;
    logic          r_valid1;
    logic [31:0]   r_pc1;
    logic [31:0]   r_inst1;
    logic          r_valid2;
    logic [31:0]   r_pc2;
    logic [31:0]   r_inst2;
    logic          empty;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: plain FIFO of {pc, inst}.
    logic [63:0] q[$];

    inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .w_ena    (w_ena),
        .w_pc     (w_pc),
        .w_inst   (w_inst),
        .full     (full),
        .r_ena1   (r_ena1),
        .r_ena2   (r_ena2),
        .r_valid1 (r_valid1),
        .r_pc1    (r_pc1),
        .r_inst1  (r_inst1),
        .r_valid2 (r_valid2),
        .r_pc2    (r_pc2),
        .r_inst2  (r_inst2),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs seen at the edge.
    always @(posedge clk) begin
        int n;
        int p;
        bit push;
        if (!rst || flush) begin
            q.delete();
        end else begin
            n    = q.size();
            p    = ((r_ena1 && n >= 1) ? 1 : 0) + ((r_ena1 && r_ena2 && n >= 2) ? 1 : 0);
            push = w_ena && (n < DEPTH);
            for (int i = 0; i < p; i++) void'(q.pop_front());
            if (push) q.push_back({w_pc, w_inst});
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("m_count",  32'(count),    32'(n));
        chk("m_empty",  32'(empty),    32'(n == 0));
        chk("m_full",   32'(full),     32'(n == DEPTH));
        chk("m_valid1", 32'(r_valid1), 32'(n >= 1));
        chk("m_valid2", 32'(r_valid2), 32'(n >= 2));
        chk("m_pc1",    r_pc1,   (n >= 1) ? q[0][63:32] : 32'h0);
        chk("m_inst1",  r_inst1, (n >= 1) ? q[0][31:0]  : 32'h0);
        chk("m_pc2",    r_pc2,   (n >= 2) ? q[1][63:32] : 32'h0);
        chk("m_inst2",  r_inst2, (n >= 2) ? q[1][31:0]  : 32'h0);
        chk("inv_full_empty", 32'(full && empty), 32'h0);
        chk("inv_count_max",  32'(count > (AW+1)'(DEPTH)), 32'h0);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [31:0] pc, input logic [31:0] inst,
                         input logic e1, input logic e2, input logic fl);
        w_ena  = we;
        w_pc   = pc;
        w_inst = inst;
        r_ena1 = e1;
        r_ena2 = e2;
        flush  = fl;
        step();
        w_ena  = 1'b0;
        w_pc   = 32'h0;
        w_inst = 32'h0;
        r_ena1 = 1'b0;
        r_ena2 = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        drive(1'b1, pc, inst, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int kinds[6];
        rst = 1'b0; flush = 1'b0; w_ena = 1'b0; w_pc = '0; w_inst = '0;
        r_ena1 = 1'b0; r_ena2 = 1'b0;

        // Reset and single fill
        step();
        step();
        chk("rst_empty",  32'(empty),    32'h1);
        chk("rst_full",   32'(full),     32'h0);
        chk("rst_valid1", 32'(r_valid1), 32'h0);
        chk("rst_pc1",    r_pc1,         32'h0);
        chk("rst_count",  32'(count),    32'h0);
        rst = 1'b1;
        push(32'hbfc00000, 32'h24010001);
        chk("fill_valid1", 32'(r_valid1), 32'h1);
        chk("fill_pc1",    r_pc1,         32'hbfc00000);
        chk("fill_inst1",  r_inst1,       32'h24010001);
        chk("fill_valid2", 32'(r_valid2), 32'h0);
        chk("fill_count",  32'(count),    32'h1);

        // Dual pop in order
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("flush0_count", 32'(count), 32'h0);
        for (int i = 0; i < 4; i++) push(32'hbfc00000 + 32'(4 * i), 32'h1000 + 32'(i));
        chk("dual_pre_pc1", r_pc1, 32'hbfc00000);
        chk("dual_pre_pc2", r_pc2, 32'hbfc00004);
        chk("dual_pre_cnt", 32'(count), 32'h4);
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("dual_post_pc1", r_pc1, 32'hbfc00008);
        chk("dual_post_pc2", r_pc2, 32'hbfc0000c);
        chk("dual_post_cnt", 32'(count), 32'h2);

        // Full and drop
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(4 * i), 32'(i));
        chk("full_flag",  32'(full),  32'h1);
        chk("full_count", 32'(count), 32'd16);
        push(32'hdead0000, 32'hdeaddead);
        chk("drop_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_pc", r_pc1, 32'h100 + 32'(4 * i));
            drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'h1);

        // Wrap-around ordering (pointers at 0 here)
        for (int i = 0; i < 12; i++) push(32'h200 + 32'(4 * i), 32'h2000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            chk("wrap_pop_a", r_pc1, 32'h200 + 32'(4 * i));
            drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 12; i < 20; i++) push(32'h200 + 32'(4 * i), 32'h2000 + 32'(i));
        chk("wrap_count", 32'(count), 32'd10);
        // Head at index 10: single, then doubles landing slot 1 on index 15.
        kinds = '{1, 2, 2, 2, 2, 1};
        e = 10;
        foreach (kinds[k]) begin
            chk("wrap_pc1", r_pc1, 32'h200 + 32'(4 * e));
            if (kinds[k] == 2) chk("wrap_pc2", r_pc2, 32'h200 + 32'(4 * (e + 1)));
            drive(1'b0, 0, 0, 1'b1, kinds[k] == 2, 1'b0);
            e += kinds[k];
        end
        chk("wrap_empty", 32'(empty), 32'h1);

        // Flush priority
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(4 * i), 32'h3000 + 32'(i));
        chk("fl_pre_cnt", 32'(count), 32'h5);
        drive(1'b1, 32'hfeed0000, 32'hfeedfeed, 1'b1, 1'b1, 1'b1);
        chk("fl_count",  32'(count),    32'h0);
        chk("fl_empty",  32'(empty),    32'h1);
        chk("fl_valid1", 32'(r_valid1), 32'h0);
        push(32'h400, 32'h55);
        chk("fl_wr_pc",   r_pc1,   32'h400);
        chk("fl_wr_inst", r_inst1, 32'h55);

        // Edge pops: count 1, double pop + push
        drive(1'b1, 32'h500, 32'h66, 1'b1, 1'b1, 1'b0);
        chk("edge_count",  32'(count),    32'h1);
        chk("edge_pc1",    r_pc1,         32'h500);
        chk("edge_valid2", 32'(r_valid2), 32'h0);
        push(32'h504, 32'h67);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("ena2_only_cnt", 32'(count), 32'h2);
        chk("ena2_only_pc1", r_pc1,      32'h500);
        // count 2, double pop + push
        drive(1'b1, 32'h508, 32'h68, 1'b1, 1'b1, 1'b0);
        chk("dp2_count", 32'(count), 32'h1);
        chk("dp2_pc1",   r_pc1,      32'h508);
        // Push and pop on empty
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h600, 32'h77, 1'b1, 1'b1, 1'b0);
        chk("emp_pp_count", 32'(count), 32'h1);
        chk("emp_pp_pc1",   r_pc1,      32'h600);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
